// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the CPU core and its debug streaming path.
package cpu_pkg;
    localparam int BIT_WIDTH = 8;
    localparam int DEBUG_BYTES = 32;
    localparam logic [BIT_WIDTH-1:0] DEBUG_SYNC_BYTE = 8'hA5;
    typedef enum logic [1:0] {IDLE, SEND, CKSUM} debug_stream_state_t;
endpackage

// File: rtl/debug_frame_streamer.sv
// debug_frame_streamer: snapshots the debug vector on capture and streams it as
// sync byte, payload bytes and XOR checksum over a valid/ready byte interface.
module debug_frame_streamer #(
    parameter int DEBUG_BYTES = cpu_pkg::DEBUG_BYTES,
    parameter logic [7:0] SYNC_BYTE = cpu_pkg::DEBUG_SYNC_BYTE
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic [8:DEBUG_BYTES*8-1]        debug_port_vector,
    input  logic                            capture,
    output logic [cpu_pkg::BIT_WIDTH-1:0]   tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            busy,
    output logic [7:0]                      overrun_count
);
    import cpu_pkg::*;

    localparam int IW = $clog2(DEBUG_BYTES);

    debug_stream_state_t      state;
    logic [8:DEBUG_BYTES*8-1] snapshot;
    logic [IW-1:0]            index;
    logic [7:0]               checksum;

    // Byte k occupies bits k*8 (MSB) .. k*8+7 of the ascending-range vector.
    function automatic logic [7:0] pick(input logic [8:DEBUG_BYTES*8-1] v, input logic [IW-1:0] i);
        return v[{i, 3'b000} +: 8];
    endfunction

    assign tx_valid = state != IDLE;
    assign busy     = state != IDLE;
    assign tx_data  = state == CKSUM ? checksum :
                      state == SEND  ? (index == '0 ? SYNC_BYTE : pick(snapshot, index)) : 8'h00;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            snapshot      <= '0;
            index         <= '0;
            checksum      <= '0;
            overrun_count <= '0;
        end else begin
            if (capture && state != IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
            case (state)
                IDLE: if (capture) begin
                    snapshot <= debug_port_vector;
                    index    <= '0;
                    checksum <= '0;
                    state    <= SEND;
                end
                SEND: if (tx_ready) begin
                    checksum <= checksum ^ tx_data;
                    if (index == IW'(DEBUG_BYTES - 1))
                        state <= CKSUM;
                    else
                        index <= index + 1'b1;
                end
                CKSUM: if (tx_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_frame_streamer.sv
// tb_debug_frame_streamer: randomized frames checked by a byte-queue scoreboard;
// the monitor pops one expected byte per observed handshake.
module tb_debug_frame_streamer;
    import cpu_pkg::*;

    localparam int NB = DEBUG_BYTES;

    logic clk = 0, nreset = 1, capture = 0, tx_ready = 0;
    logic tx_valid, busy;
    logic [7:0] tx_data, overrun_count;
    logic [8:NB*8-1] vec = '0;

    int checks = 0, fails = 0, rmode = 0, cyc = 0, n = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_ovr = 0;
    logic [7:0] bytes[NB];

    debug_frame_streamer dut (
        .clk(clk), .nreset(nreset), .debug_port_vector(vec), .capture(capture),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Sink readiness: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rmode)
            0: tx_ready = 1;
            1: tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 0;
        endcase
    end

    logic pv = 0, pr = 0;
    logic [7:0] pd = 0;
    always @(negedge clk) begin
        if (nreset) begin
            if (pv && !pr) begin
                check("hold_valid", 32'(tx_valid), 1);
                check("hold_data", 32'(tx_data), 32'(pd));
            end
            if (tx_valid && exp_q.size() == 0)
                check("spurious_valid", 32'(tx_valid), 0);
            else if (tx_valid && tx_ready)
                check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
            pv = tx_valid; pr = tx_ready; pd = tx_data;
        end else begin
            pv = 0; pr = 0; pd = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bytes();
        for (int k = 1; k < NB; k++) bytes[k] = 8'($urandom);
    endtask

    // A capture is accepted only when no frame is outstanding; otherwise it is an overrun.
    task automatic issue();
        logic [7:0] c;
        for (int k = 1; k < NB; k++) vec[k*8 +: 8] = bytes[k];
        if (exp_q.size() == 0) begin
            c = DEBUG_SYNC_BYTE;
            exp_q.push_back(DEBUG_SYNC_BYTE);
            for (int k = 1; k < NB; k++) begin
                exp_q.push_back(bytes[k]);
                c ^= bytes[k];
            end
            exp_q.push_back(c);
        end else if (exp_ovr != 8'hFF) begin
            exp_ovr++;
        end
        capture = 1;
        tick();
        capture = 0;
    endtask

    task automatic wait_idle(input bit scramble, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 3000) begin
            if (scramble) for (int k = 1; k < NB; k++) vec[k*8 +: 8] = 8'($urandom);
            tick();
            cycles++;
        end
        if (exp_q.size() != 0) begin
            check("frame_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        check("busy_after_frame", 32'(busy), 0);
        check("valid_after_frame", 32'(tx_valid), 0);
    endtask

    initial begin
        #2 nreset = 0;
        #10;
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun_count), 0);
        tick();
        nreset = 1;
        tick();

        rmode = 0;
        for (int k = 1; k < NB; k++) bytes[k] = 8'h00;
        issue();
        wait_idle(0, n);
        check("frame_cycles", 32'(n), NB + 1);

        bytes[1] = 8'h12;
        bytes[NB-1] = 8'h0F;
        issue();
        wait_idle(0, n);
        check("frame_cycles2", 32'(n), NB + 1);

        rmode = 1;
        issue();
        wait_idle(0, n);

        rmode = 0;
        rand_bytes();
        issue();
        repeat (4) tick();
        issue();
        for (int g = 0; g < 100 && exp_q.size() > 1; g++) tick();
        issue();
        wait_idle(0, n);
        check("overrun_two", 32'(overrun_count), 32'(exp_ovr));

        rand_bytes();
        issue();
        wait_idle(1, n);

        rmode = 2;
        repeat (5) begin
            rand_bytes();
            issue();
            wait_idle(1, n);
        end

        rmode = 0;
        rand_bytes();
        issue();
        repeat (10) tick();
        nreset = 0;
        #1;
        check("async_rst_valid", 32'(tx_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        exp_q.delete();
        exp_ovr = 0;
        repeat (3) tick();
        nreset = 1;
        repeat (6) tick();
        check("post_rst_valid", 32'(tx_valid), 0);
        check("post_rst_overrun", 32'(overrun_count), 32'(exp_ovr));
        rand_bytes();
        issue();
        wait_idle(0, n);
        check("post_rst_cycles", 32'(n), NB + 1);

        rmode = 3;
        rand_bytes();
        issue();
        repeat (300) issue();
        rmode = 0;
        wait_idle(0, n);
        check("overrun_sat", 32'(overrun_count), 32'(exp_ovr));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/debug_frame_streamer.md
Name: debug_frame_streamer

Overview:
- Downstream consumer of the CPU core's debug port.
- On a capture strobe, snapshots the DEBUG_BYTES-wide debug vector and emits it as a framed byte stream: sync byte, payload bytes, XOR checksum.
- Output is a valid/ready byte interface feeding the board-level UART transmitter in top.
- Replaces ad-hoc byte muxing of the debug vector at top level.

Parameters:
- DEBUG_BYTES, 32, frame length excluding checksum; byte 0 is the sync byte, bytes 1..DEBUG_BYTES-1 come from the debug vector.
- SYNC_BYTE, 8'hA5, value sent in byte slot 0 of every frame.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- debug_port_vector  in  [8:DEBUG_BYTES*8-1]  live debug vector from the CPU core. Byte k (1..DEBUG_BYTES-1) is bits k*8 (MSB) through k*8+7 (LSB).
- capture  in  1  single-cycle request to snapshot the vector and send a frame.
- tx_data  out  8  current stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts tx_data this cycle.
- busy  out  1  frame in progress (state != IDLE).
- overrun_count  out  8  saturating count of captures dropped while busy.

Behaviour:
- Reset (async assert, nreset=0): state=IDLE, tx_valid=0, tx_data=0, busy=0, overrun_count=0, snapshot=0, index=0, checksum=0.
  - Asserting reset mid-frame aborts the frame immediately; no partial completion after release.
- States: IDLE, SEND, CKSUM.
- IDLE:
  - capture=1 at a rising edge: load snapshot <= debug_port_vector, index <= 0, checksum <= 0, go to SEND.
  - Latency: tx_valid=1 with tx_data=SYNC_BYTE in the cycle after capture.
- SEND:
  - tx_data = SYNC_BYTE when index=0, else snapshot byte[index].
  - Handshake when tx_valid && tx_ready: checksum <= checksum ^ tx_data, then:
    - if index==DEBUG_BYTES-1, go to CKSUM;
    - otherwise index <= index+1.
- CKSUM:
  - tx_data = checksum, which is the XOR of all DEBUG_BYTES bytes sent.
  - On handshake, go to IDLE; tx_valid drops the next cycle.
- Handshake rules:
  - tx_valid never drops and tx_data never changes while tx_valid && !tx_ready.
  - tx_ready is ignored when tx_valid=0.
  - With tx_ready held at 1, back-to-back bytes stream one per cycle: frame is DEBUG_BYTES+1 cycles of valid.
- Snapshot is frozen for the whole frame; changes on debug_port_vector during SEND/CKSUM do not affect the frame.
- Capture while busy (SEND or CKSUM, including the cycle the checksum handshake completes) is dropped.
  - Each drop increments overrun_count, saturating at 8'hFF.
  - Capture is accepted only in IDLE, so the minimum gap between frames is one idle cycle.
- Index counter is $clog2(DEBUG_BYTES) bits and never wraps past DEBUG_BYTES-1.
- busy is a registered-state decode: high from the cycle after an accepted capture until the cycle after the checksum handshake.

Decomposition:
- Shared package cpu_pkg holds:
  - BIT_WIDTH, DEBUG_BYTES, DEBUG_SYNC_BYTE constants;
  - typedef enum logic [1:0] {IDLE, SEND, CKSUM} debug_stream_state_t.
- Byte selection (index -> snapshot byte) is a combinational function inside the module; no sub-module is needed.
- The UART transmitter stays a separate module in top, connected via tx_data/tx_valid/tx_ready.

Test Plan:
- Vector all zeros, capture pulse, tx_ready=1 -> A5, 31 x 00, checksum A5; 33 consecutive valid cycles; busy low one cycle after the last byte.
- Vector byte1=8'h12, byte31=8'h0F, rest 0 -> stream A5,12,00...,0F, checksum A5^12^0F=8'hB8.
- tx_ready toggles 1,0,0,1 repeatedly -> tx_data/tx_valid held stable through stalls; byte order and checksum identical to the no-stall run.
- Capture pulses at frame cycle 5 and on the checksum-handshake cycle -> overrun_count=2, current frame unaffected; 300 busy captures -> overrun_count saturates at FF.
- nreset asserted at byte index 10, released 3 cycles later -> tx_valid=0 and busy=0 asynchronously; no bytes until the next capture, which starts again with A5.
- debug_port_vector changed every cycle during a frame -> emitted bytes match the vector value at the capture edge.
